// File: rtl/bnn_pkg.sv
// rtl/bnn_pkg.sv - shared constants and types for the BNN datapath
package bnn_pkg;

    localparam int BNN_ADDR_WIDTH = 12;
    localparam int BNN_DATA_WIDTH = 16;

    typedef enum logic [1:0] {IDLE, ACCUM, WRITE, DONE} act_pack_state_t;

    typedef logic [15:0] bnn_word_t;

endpackage

// File: rtl/bnn_act_packer.sv
// rtl/bnn_act_packer.sv - binarizes popcounts and packs activation bits into SRAM words
// BNN_ACT_PACK_MSB_FIRST_EN: store bit k of a word at position DATA_WIDTH-1-k instead of k
module bnn_act_packer
    import bnn_pkg::*;
#(
    parameter int ADDR_WIDTH = BNN_ADDR_WIDTH,
    parameter int DATA_WIDTH = BNN_DATA_WIDTH,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] num_outputs,
    input  logic [CNT_WIDTH-1:0]  threshold,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CNT_WIDTH-1:0]  in_popcount,
    output logic                  wr_enable,
    output logic [ADDR_WIDTH-1:0] dut_sram_write_address,
    output logic [DATA_WIDTH-1:0] dut_sram_write_data,
    output logic                  busy,
    output logic                  done
);

    localparam int IDX_W = $clog2(DATA_WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    act_pack_state_t       r_state;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [ADDR_WIDTH-1:0] r_remaining;
    logic [CNT_WIDTH-1:0]  r_threshold;
    logic [DATA_WIDTH-1:0] r_word;
    logic [IDX_W-1:0]      r_bit_idx;
    logic [ADDR_WIDTH-1:0] r_word_idx;
    logic                  r_in_ready;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_wr_enable;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;

    logic                  w_bit;
    logic                  w_handshake;
    logic                  w_close;
    logic [IDX_W-1:0]      w_pos;
    logic [DATA_WIDTH-1:0] w_word_next;

    assign w_bit       = (in_popcount >= r_threshold);
    assign w_handshake = in_valid && r_in_ready;
    assign w_close     = (r_bit_idx == LAST_IDX) || (r_remaining == ADDR_WIDTH'(1));

`ifdef BNN_ACT_PACK_MSB_FIRST_EN
    assign w_pos = LAST_IDX - r_bit_idx;
`else
    assign w_pos = r_bit_idx;
`endif

    always_comb begin
        w_word_next        = r_word;
        w_word_next[w_pos] = w_bit;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_base      <= '0;
            r_remaining <= '0;
            r_threshold <= '0;
            r_word      <= '0;
            r_bit_idx   <= '0;
            r_word_idx  <= '0;
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_wr_enable <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
        end else begin
            r_wr_enable <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_base      <= base_addr;
                        r_remaining <= num_outputs;
                        r_threshold <= threshold;
                        r_word      <= '0;
                        r_bit_idx   <= '0;
                        r_word_idx  <= '0;
                        r_busy      <= 1'b1;
                        if (num_outputs == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state    <= ACCUM;
                            r_in_ready <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (w_handshake) begin
                        r_word      <= w_word_next;
                        r_remaining <= r_remaining - ADDR_WIDTH'(1);
                        r_bit_idx   <= r_bit_idx + IDX_W'(1);
                        // Word full or layer exhausted: emit the word including this bit
                        if (w_close) begin
                            r_state     <= WRITE;
                            r_in_ready  <= 1'b0;
                            r_wr_enable <= 1'b1;
                            r_wr_addr   <= r_base + r_word_idx;
                            r_wr_data   <= w_word_next;
                        end
                    end
                end
                WRITE: begin
                    r_word     <= '0;
                    r_word_idx <= r_word_idx + ADDR_WIDTH'(1);
                    r_bit_idx  <= '0;
                    if (r_remaining == '0) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state    <= ACCUM;
                        r_in_ready <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready               = r_in_ready;
    assign busy                   = r_busy;
    assign done                   = r_done;
    assign wr_enable              = r_wr_enable;
    assign dut_sram_write_address = r_wr_addr;
    assign dut_sram_write_data    = r_wr_data;

endmodule

// File: tb/tb_bnn_act_packer.sv
// tb/tb_bnn_act_packer.sv - self-checking bench for bnn_act_packer
module tb_bnn_act_packer;
    import bnn_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [11:0] base_addr = '0;
    logic [11:0] num_outputs = '0;
    logic [7:0]  threshold = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_popcount = '0;
    logic        wr_enable;
    logic [11:0] wr_addr;
    logic [15:0] wr_data;
    logic        busy;
    logic        done;

    bnn_act_packer dut (
        .clk                    (clk),
        .reset                  (reset),
        .start                  (start),
        .base_addr              (base_addr),
        .num_outputs            (num_outputs),
        .threshold              (threshold),
        .in_valid               (in_valid),
        .in_ready               (in_ready),
        .in_popcount            (in_popcount),
        .wr_enable              (wr_enable),
        .dut_sram_write_address (wr_addr),
        .dut_sram_write_data    (wr_data),
        .busy                   (busy),
        .done                   (done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int busy_cnt = 0;
    int ready_in_write = 0;

    logic [11:0] obs_addr[$];
    bnn_word_t   obs_data[$];
    int          obs_cyc[$];
    logic [7:0]  pcs[$];
    logic [11:0] exp_addr[$];
    bnn_word_t   exp_data[$];
    logic [11:0] cur_base;
    int          cur_n;
    int          cur_th;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wr_enable) begin
            obs_addr.push_back(wr_addr);
            obs_data.push_back(wr_data);
            obs_cyc.push_back(cyc);
            if (in_ready) ready_in_write++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (busy) busy_cnt++;
    end

    task automatic clear_obs();
        obs_addr.delete();
        obs_data.delete();
        obs_cyc.delete();
        pcs.delete();
        done_cnt = 0;
        busy_cnt = 0;
        ready_in_write = 0;
    endtask

    // Reference: activation i lands in word i/16 at slot i%16 (mirrored for MSB-first)
    function automatic void build_model();
        int nw;
        int k;
        exp_addr.delete();
        exp_data.delete();
        nw = (cur_n + 15) / 16;
        for (int w = 0; w < nw; w++) begin
            exp_addr.push_back(12'((int'(cur_base) + w) % 4096));
            exp_data.push_back(16'h0000);
        end
        for (int i = 0; i < pcs.size(); i++) begin
            if (int'(pcs[i]) >= cur_th) begin
`ifdef BNN_ACT_PACK_MSB_FIRST_EN
                k = 15 - (i % 16);
`else
                k = i % 16;
`endif
                exp_data[i / 16] = exp_data[i / 16] | (16'h0001 << k);
            end
        end
    endfunction

    task automatic start_layer(input logic [11:0] b, input logic [11:0] n, input logic [7:0] th);
        @(negedge clk);
        start = 1'b1;
        base_addr = b;
        num_outputs = n;
        threshold = th;
        cur_base = b;
        cur_n = int'(n);
        cur_th = int'(th);
        @(negedge clk);
        start = 1'b0;
    endtask

    // mode 0: random, 1: alternating 6/4, 2: equal to threshold
    task automatic feed(input int n, input int mode, input int gap_pct, input int bs_at);
        int sent = 0;
        int iter = 0;
        bit bs_done = 0;
        logic [7:0] pc;
        while (sent < n && iter < 3000) begin
            start = 1'b0;
            if (!bs_done && bs_at >= 0 && sent == bs_at) begin
                start = 1'b1;
                base_addr = cur_base ^ 12'h200;
                bs_done = 1;
            end
            case (mode)
                1: pc = (sent % 2 == 0) ? 8'd6 : 8'd4;
                2: pc = 8'(cur_th);
                default: pc = ($urandom_range(0, 7) == 0) ? 8'd255 : 8'($urandom_range(0, 15));
            endcase
            in_valid = ($urandom_range(0, 99) >= gap_pct);
            in_popcount = pc;
            if (in_valid && in_ready) begin
                pcs.push_back(pc);
                sent++;
            end
            iter++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        start = 1'b0;
        if (sent < n) begin
            miscompares++;
            $display("FAIL feed_budget: accepted %0d bits, required %0d", sent, n);
        end
    endtask

    task automatic wait_done();
        int t = 0;
        while (done_cnt == 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        vectors++;
        if (done_cnt == 0) begin
            miscompares++;
            $display("FAIL done_timeout: no done pulse within %0d cycles", t);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #2;
        vectors += 6;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy); end
        if (done !== 1'b0) begin miscompares++; $display("FAIL rst_done: got %b want 0", done); end
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        if (wr_enable !== 1'b0) begin miscompares++; $display("FAIL rst_wr_en: got %b want 0", wr_enable); end
        if (wr_addr !== 12'h000) begin miscompares++; $display("FAIL rst_addr: got %h want 000", wr_addr); end
        if (wr_data !== 16'h0000) begin miscompares++; $display("FAIL rst_data: got %h want 0000", wr_data); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_lsb_pattern();
        bnn_word_t want;
`ifdef BNN_ACT_PACK_MSB_FIRST_EN
        want = 16'hAAAA;
`else
        want = 16'h5555;
`endif
        clear_obs();
        start_layer(12'h010, 12'd16, 8'd5);
        feed(16, 1, 0, -1);
        wait_done();
        build_model();
        vectors++;
        if (obs_addr.size() != 1) begin
            miscompares++;
            $display("FAIL pat_count: got %0d writes want 1", obs_addr.size());
        end else begin
            vectors += 5;
            if (obs_addr[0] !== 12'h010) begin miscompares++; $display("FAIL pat_addr: got %h want 010", obs_addr[0]); end
            if (obs_data[0] !== want) begin miscompares++; $display("FAIL pat_data: got %h want %h", obs_data[0], want); end
            if (obs_data[0] !== exp_data[0]) begin miscompares++; $display("FAIL pat_model: got %h want %h", obs_data[0], exp_data[0]); end
            if (done_cyc !== obs_cyc[0] + 1) begin miscompares++; $display("FAIL pat_done_lat: got cycle %0d want %0d", done_cyc, obs_cyc[0] + 1); end
            if (ready_in_write !== 0) begin miscompares++; $display("FAIL pat_ready_wr: got %0d want 0", ready_in_write); end
        end
    endtask

    task automatic test_partial();
        clear_obs();
        start_layer(12'h000, 12'd20, 8'd3);
        feed(20, 2, 0, -1);
        wait_done();
        build_model();
        vectors += 2;
        if (obs_addr.size() != 2) begin
            miscompares++;
            $display("FAIL part_count: got %0d writes want 2", obs_addr.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                vectors += 2;
                if (obs_addr[i] !== exp_addr[i]) begin miscompares++; $display("FAIL part_addr%0d: got %h want %h", i, obs_addr[i], exp_addr[i]); end
                if (obs_data[i] !== exp_data[i]) begin miscompares++; $display("FAIL part_data%0d: got %h want %h", i, obs_data[i], exp_data[i]); end
            end
        end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL part_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_zero();
        clear_obs();
        start_layer(12'h123, 12'd0, 8'd7);
        in_valid = 1'b1;
        wait_done();
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        vectors += 3;
        if (obs_addr.size() != 0) begin miscompares++; $display("FAIL zero_writes: got %0d want 0", obs_addr.size()); end
        if (done_cnt != 1) begin miscompares++; $display("FAIL zero_done: got %0d pulses want 1", done_cnt); end
        if (busy_cnt != 1) begin miscompares++; $display("FAIL zero_busy: got %0d cycles want 1", busy_cnt); end
    endtask

    task automatic test_wrap();
        clear_obs();
        start_layer(12'hFFF, 12'd32, 8'($urandom_range(0, 15)));
        feed(32, 0, 40, -1);
        wait_done();
        build_model();
        vectors += 2;
        if (ready_in_write != 0) begin miscompares++; $display("FAIL wrap_ready_wr: got %0d want 0", ready_in_write); end
        if (obs_addr.size() != 2) begin
            miscompares++;
            $display("FAIL wrap_count: got %0d writes want 2", obs_addr.size());
        end else begin
            vectors += 2;
            if (obs_addr[0] !== 12'hFFF) begin miscompares++; $display("FAIL wrap_addr0: got %h want fff", obs_addr[0]); end
            if (obs_addr[1] !== 12'h000) begin miscompares++; $display("FAIL wrap_addr1: got %h want 000", obs_addr[1]); end
            for (int i = 0; i < 2; i++) begin
                vectors++;
                if (obs_data[i] !== exp_data[i]) begin miscompares++; $display("FAIL wrap_data%0d: got %h want %h", i, obs_data[i], exp_data[i]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_obs();
        start_layer(12'h050, 12'd40, 8'd4);
        feed(7, 0, 20, -1);
        #2 reset = 1'b1;
        #1;
        vectors += 6;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_busy: got %b want 0", busy); end
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL mid_in_ready: got %b want 0", in_ready); end
        if (wr_enable !== 1'b0) begin miscompares++; $display("FAIL mid_wr_en: got %b want 0", wr_enable); end
        if (wr_addr !== 12'h000) begin miscompares++; $display("FAIL mid_addr: got %h want 000", wr_addr); end
        if (wr_data !== 16'h0000) begin miscompares++; $display("FAIL mid_data: got %h want 0000", wr_data); end
        if (done !== 1'b0) begin miscompares++; $display("FAIL mid_done: got %b want 0", done); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        vectors += 2;
        if (obs_addr.size() != 0) begin miscompares++; $display("FAIL mid_writes: got %0d want 0", obs_addr.size()); end
        if (done_cnt != 0) begin miscompares++; $display("FAIL mid_done_cnt: got %0d want 0", done_cnt); end
        clear_obs();
        start_layer(12'h060, 12'd16, 8'($urandom_range(0, 15)));
        feed(16, 0, 30, -1);
        wait_done();
        build_model();
        vectors++;
        if (obs_addr.size() != 1) begin
            miscompares++;
            $display("FAIL post_count: got %0d writes want 1", obs_addr.size());
        end else begin
            vectors += 2;
            if (obs_addr[0] !== exp_addr[0]) begin miscompares++; $display("FAIL post_addr: got %h want %h", obs_addr[0], exp_addr[0]); end
            if (obs_data[0] !== exp_data[0]) begin miscompares++; $display("FAIL post_data: got %h want %h", obs_data[0], exp_data[0]); end
        end
    endtask

    task automatic test_start_busy();
        clear_obs();
        start_layer(12'h100, 12'd32, 8'd8);
        feed(32, 0, 25, 5);
        wait_done();
        build_model();
        vectors += 2;
        if (done_cnt != 1) begin miscompares++; $display("FAIL sb_done: got %0d pulses want 1", done_cnt); end
        if (obs_addr.size() != 2) begin
            miscompares++;
            $display("FAIL sb_count: got %0d writes want 2", obs_addr.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                vectors += 2;
                if (obs_addr[i] !== exp_addr[i]) begin miscompares++; $display("FAIL sb_addr%0d: got %h want %h", i, obs_addr[i], exp_addr[i]); end
                if (obs_data[i] !== exp_data[i]) begin miscompares++; $display("FAIL sb_data%0d: got %h want %h", i, obs_data[i], exp_data[i]); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        for (int layer = 0; layer < 6; layer++) begin
            clear_obs();
            n = $urandom_range(1, 50);
            start_layer(12'($urandom_range(0, 4095)), 12'(n), 8'($urandom_range(0, 15)));
            feed(n, 0, $urandom_range(0, 50), -1);
            wait_done();
            build_model();
            vectors += 2;
            if (ready_in_write != 0) begin miscompares++; $display("FAIL b2b%0d_ready_wr: got %0d want 0", layer, ready_in_write); end
            if (obs_addr.size() != exp_addr.size()) begin
                miscompares++;
                $display("FAIL b2b%0d_count: got %0d writes want %0d", layer, obs_addr.size(), exp_addr.size());
            end else begin
                for (int i = 0; i < exp_addr.size(); i++) begin
                    vectors += 2;
                    if (obs_addr[i] !== exp_addr[i]) begin miscompares++; $display("FAIL b2b%0d_addr%0d: got %h want %h", layer, i, obs_addr[i], exp_addr[i]); end
                    if (obs_data[i] !== exp_data[i]) begin miscompares++; $display("FAIL b2b%0d_data%0d: got %h want %h", layer, i, obs_data[i], exp_data[i]); end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_lsb_pattern();
        test_partial();
        test_zero();
        test_wrap();
        test_reset_mid();
        test_start_busy();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
